clock_core_settable: RTL and testbench

- Single-clock-domain hh:mm:ss timekeeping core; successor to the ripple-clocked counter chain.
- All counters run on clk_in_50M with one-cycle enables; no derived clocks.
- Adds a parametrised input frequency, 12/24-hour mode, a key-driven time-setting FSM and an hh:mm alarm match.
- Sits between the board clock/keys and the BCD-to-7-segment decoders.

---
 rtl/clock_core_settable.sv | 155 +++++++++++++++
 tb/tb_clock_core_settable.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_core_settable.sv
// rtl/clock_core_settable.sv - single-clock hh:mm:ss BCD timekeeping core
// Key-driven time setting, 12/24-hour mode and hh:mm alarm strobe.
module clock_core_settable #(
  parameter int CLK_HZ    = 50000000,
  parameter int HOUR_MODE = 24
) (
  input  logic       clk_in_50M,
  input  logic       resetControl,
  input  logic       mode_key,
  input  logic       inc_key,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_min,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       pm,
  output logic [1:0] set_state,
  output logic       blink,
  output logic       sec_pulse,
  output logic       day_pulse,
  output logic       alarm_pulse
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_SET_HOUR = 2'd1;
  localparam logic [1:0] ST_SET_MIN  = 2'd2;

  localparam int            PW         = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(CLK_HZ / 2 - 1);
  localparam bit            MODE12     = (HOUR_MODE == 12);
  localparam logic [7:0]    HOUR_RESET = MODE12 ? 8'h12 : 8'h00;

  logic [PW-1:0] presc;
  logic [1:0]    state;

  // Packed-BCD increment; the ones digit carries into tens at 9.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else
      bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] sixty_inc(input logic [7:0] v);
    sixty_inc = (v == 8'h59) ? 8'h00 : bcd_inc(v);
  endfunction

  function automatic logic [7:0] hour_inc(input logic [7:0] v);
    if (MODE12)
      hour_inc = (v == 8'h12) ? 8'h01 : bcd_inc(v);
    else
      hour_inc = (v == 8'h23) ? 8'h00 : bcd_inc(v);
  endfunction

  logic       sec_wrap;
  logic       hour_carry;
  logic [7:0] sec_nxt;
  logic [7:0] min_nxt;
  logic [7:0] hour_nxt;
  logic       pm_nxt;
  logic       day_roll;
  logic       alarm_hit;

  // Time values the counters take on the next seconds tick.
  always_comb begin
    sec_wrap   = (sec_bcd == 8'h59);
    hour_carry = sec_wrap && (min_bcd == 8'h59);
    sec_nxt    = sixty_inc(sec_bcd);
    min_nxt    = sec_wrap ? sixty_inc(min_bcd) : min_bcd;
    hour_nxt   = hour_carry ? hour_inc(hour_bcd) : hour_bcd;
    pm_nxt     = pm ^ (MODE12 && hour_carry && (hour_bcd == 8'h11));
    if (MODE12)
      day_roll = hour_carry && (hour_bcd == 8'h11) && pm;
    else
      day_roll = hour_carry && (hour_bcd == 8'h23);
    alarm_hit  = alarm_en && (hour_nxt == alarm_hour) && (min_nxt == alarm_min)
                 && (sec_nxt == 8'h00) && !pm_nxt;
  end

  always_ff @(posedge clk_in_50M or posedge resetControl) begin
    if (resetControl) begin
      presc       <= '0;
      state       <= ST_RUN;
      sec_bcd     <= 8'h00;
      min_bcd     <= 8'h00;
      hour_bcd    <= HOUR_RESET;
      pm          <= 1'b0;
      blink       <= 1'b0;
      sec_pulse   <= 1'b0;
      day_pulse   <= 1'b0;
      alarm_pulse <= 1'b0;
    end else begin
      sec_pulse   <= 1'b0;
      day_pulse   <= 1'b0;
      alarm_pulse <= 1'b0;
      case (state)
        ST_RUN: begin
          if (mode_key) begin
            // A tick landing on the same edge is dropped on purpose.
            state <= ST_SET_HOUR;
            presc <= '0;
            blink <= 1'b0;
          end else if (presc == PRE_LAST) begin
            presc       <= '0;
            sec_bcd     <= sec_nxt;
            min_bcd     <= min_nxt;
            hour_bcd    <= hour_nxt;
            pm          <= pm_nxt;
            sec_pulse   <= 1'b1;
            day_pulse   <= day_roll;
            alarm_pulse <= alarm_hit;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        ST_SET_HOUR, ST_SET_MIN: begin
          if (presc >= HALF_LAST) begin
            presc <= '0;
            blink <= ~blink;
          end else begin
            presc <= presc + 1'b1;
          end
          if (mode_key) begin
            if (state == ST_SET_HOUR) begin
              state <= ST_SET_MIN;
            end else begin
              state   <= ST_RUN;
              sec_bcd <= 8'h00;
              presc   <= '0;
              blink   <= 1'b0;
            end
          end else if (inc_key) begin
            if (state == ST_SET_HOUR) begin
              hour_bcd <= hour_inc(hour_bcd);
              if (MODE12 && (hour_bcd == 8'h11))
                pm <= ~pm;
            end else begin
              min_bcd <= sixty_inc(min_bcd);
            end
          end
        end
        default: begin
          state <= ST_RUN;
          presc <= '0;
          blink <= 1'b0;
        end
      endcase
    end
  end

  assign set_state = state;

endmodule

// File: tb/tb_clock_core_settable.sv
// tb/tb_clock_core_settable.sv - directed bench for clock_core_settable
// Drives a 24-hour and a 12-hour instance (CLK_HZ=10) from shared inputs.
module tb_clock_core_settable;

  logic       clk = 1'b0;
  logic       resetControl = 1'b0;
  logic       mode_key = 1'b0;
  logic       inc_key = 1'b0;
  logic       alarm_en = 1'b0;
  logic [7:0] alarm_hour = 8'h00;
  logic [7:0] alarm_min = 8'h00;

  logic [7:0] h24, m24, s24, h12, m12, s12;
  logic [1:0] st24, st12;
  logic       pm24, bl24, sp24, dp24, ap24;
  logic       pm12, bl12, sp12, dp12, ap12;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clock_core_settable #(.CLK_HZ(10), .HOUR_MODE(24)) dut24 (
    .clk_in_50M(clk), .resetControl(resetControl), .mode_key(mode_key),
    .inc_key(inc_key), .alarm_en(alarm_en), .alarm_hour(alarm_hour),
    .alarm_min(alarm_min), .hour_bcd(h24), .min_bcd(m24), .sec_bcd(s24),
    .pm(pm24), .set_state(st24), .blink(bl24), .sec_pulse(sp24),
    .day_pulse(dp24), .alarm_pulse(ap24)
  );

  clock_core_settable #(.CLK_HZ(10), .HOUR_MODE(12)) dut12 (
    .clk_in_50M(clk), .resetControl(resetControl), .mode_key(mode_key),
    .inc_key(inc_key), .alarm_en(alarm_en), .alarm_hour(alarm_hour),
    .alarm_min(alarm_min), .hour_bcd(h12), .min_bcd(m12), .sec_bcd(s12),
    .pm(pm12), .set_state(st12), .blink(bl12), .sec_pulse(sp12),
    .day_pulse(dp12), .alarm_pulse(ap12)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic m, input logic i);
    mode_key = m;
    inc_key  = i;
    @(posedge clk);
    #1;
    mode_key = 1'b0;
    inc_key  = 1'b0;
  endtask

  task automatic press_n(input logic m, input logic i, input int n);
    repeat (n) press(m, i);
  endtask

  task automatic do_reset;
    @(posedge clk);
    #3 resetControl = 1'b1;
    @(posedge clk);
    #1 resetControl = 1'b0;
  endtask

  function automatic bit bad_bcd(input logic [7:0] v);
    return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
  endfunction

  task automatic test_reset;
    tick(25);
    n_cmp++; if (s24 !== 8'h02) begin n_bad++; $display("FAIL pre_reset_sec: got %h want 02", s24); end
    @(posedge clk);
    #3 resetControl = 1'b1;
    #1;
    n_cmp++; if ({h24, m24, s24} !== 24'h000000) begin n_bad++; $display("FAIL reset_time24: got %h want 000000", {h24, m24, s24}); end
    n_cmp++; if ({h12, m12, s12, pm12} !== {24'h120000, 1'b0}) begin n_bad++; $display("FAIL reset_time12: got %h pm %b want 120000 pm 0", {h12, m12, s12}, pm12); end
    n_cmp++; if ({st24, bl24, sp24, dp24, ap24, pm24} !== 7'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000000", {st24, bl24, sp24, dp24, ap24, pm24}); end
    @(posedge clk);
    #1 resetControl = 1'b0;
  endtask

  task automatic test_count;
    int sp_cnt = 0;
    int bad = 0;
    do_reset();
    for (int c = 1; c <= 600; c++) begin
      tick(1);
      if (sp24) sp_cnt++;
      if (bad_bcd(h24) || bad_bcd(m24) || bad_bcd(s24) || bad_bcd(h12) || bad_bcd(m12) || bad_bcd(s12)) bad++;
      if (c == 10) begin
        n_cmp++; if ({s24, sp24} !== {8'h01, 1'b1}) begin n_bad++; $display("FAIL first_tick: got sec %h pulse %b want 01 1", s24, sp24); end
      end
    end
    n_cmp++; if (sp_cnt !== 60) begin n_bad++; $display("FAIL sec_pulse_count: got %0d want 60", sp_cnt); end
    n_cmp++; if ({h24, m24, s24} !== 24'h000100) begin n_bad++; $display("FAIL count_600: got %h want 000100", {h24, m24, s24}); end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL bcd_valid: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_set_fsm;
    int sp_cnt = 0;
    do_reset();
    press(1'b1, 1'b0);
    n_cmp++; if ({st24, bl24} !== {2'd1, 1'b0}) begin n_bad++; $display("FAIL enter_set_hour: got st %0d blink %b want 1 0", st24, bl24); end
    tick(4);
    n_cmp++; if (bl24 !== 1'b0) begin n_bad++; $display("FAIL blink_4: got %b want 0", bl24); end
    tick(1);
    n_cmp++; if (bl24 !== 1'b1) begin n_bad++; $display("FAIL blink_5: got %b want 1", bl24); end
    tick(4);
    n_cmp++; if (bl24 !== 1'b1) begin n_bad++; $display("FAIL blink_9: got %b want 1", bl24); end
    tick(1);
    n_cmp++; if (bl24 !== 1'b0) begin n_bad++; $display("FAIL blink_10: got %b want 0", bl24); end
    for (int i = 0; i < 25; i++) begin
      press(1'b0, 1'b1);
      if (sp24) sp_cnt++;
    end
    n_cmp++; if ({h24, m24} !== 16'h0100) begin n_bad++; $display("FAIL hour_wrap: got %h want 0100", {h24, m24}); end
    press(1'b1, 1'b0);
    n_cmp++; if (st24 !== 2'd2) begin n_bad++; $display("FAIL enter_set_min: got %0d want 2", st24); end
    for (int i = 0; i < 61; i++) begin
      press(1'b0, 1'b1);
      if (sp24) sp_cnt++;
    end
    n_cmp++; if ({h24, m24} !== 16'h0101) begin n_bad++; $display("FAIL min_wrap: got %h want 0101", {h24, m24}); end
    n_cmp++; if (sp_cnt !== 0) begin n_bad++; $display("FAIL set_no_sec_pulse: got %0d want 0", sp_cnt); end
    press(1'b1, 1'b0);
    n_cmp++; if ({st24, s24, bl24} !== {2'd0, 8'h00, 1'b0}) begin n_bad++; $display("FAIL exit_run: got st %0d sec %h blink %b want 0 00 0", st24, s24, bl24); end
    tick(9);
    n_cmp++; if ({sp24, s24} !== {1'b0, 8'h00}) begin n_bad++; $display("FAIL exit_tick9: got pulse %b sec %h want 0 00", sp24, s24); end
    tick(1);
    n_cmp++; if ({sp24, s24} !== {1'b1, 8'h01}) begin n_bad++; $display("FAIL exit_tick10: got pulse %b sec %h want 1 01", sp24, s24); end
  endtask

  task automatic test_rollover_24;
    int dp_cnt = 0;
    do_reset();
    press(1'b1, 1'b0);
    press_n(1'b0, 1'b1, 23);
    press(1'b1, 1'b0);
    press_n(1'b0, 1'b1, 59);
    press(1'b1, 1'b0);
    n_cmp++; if ({h24, m24, s24} !== 24'h235900) begin n_bad++; $display("FAIL set_2359: got %h want 235900", {h24, m24, s24}); end
    for (int c = 0; c < 600; c++) begin
      tick(1);
      if (dp24) dp_cnt++;
    end
    n_cmp++; if ({dp24, h24, m24, s24} !== {1'b1, 24'h000000}) begin n_bad++; $display("FAIL midnight24: got pulse %b time %h want 1 000000", dp24, {h24, m24, s24}); end
    n_cmp++; if (dp_cnt !== 1) begin n_bad++; $display("FAIL day_count24: got %0d want 1", dp_cnt); end
  endtask

  task automatic test_12h;
    int dp_cnt = 0;
    do_reset();
    press(1'b1, 1'b0);
    press_n(1'b0, 1'b1, 11);
    press(1'b1, 1'b0);
    press_n(1'b0, 1'b1, 59);
    press(1'b1, 1'b0);
    n_cmp++; if ({h12, m12, pm12} !== {16'h1159, 1'b0}) begin n_bad++; $display("FAIL set_1159am: got %h pm %b want 1159 pm 0", {h12, m12}, pm12); end
    for (int c = 0; c < 600; c++) begin
      tick(1);
      if (dp12) dp_cnt++;
    end
    n_cmp++; if ({h12, m12, s12, pm12} !== {24'h120000, 1'b1}) begin n_bad++; $display("FAIL noon: got %h pm %b want 120000 pm 1", {h12, m12, s12}, pm12); end
    n_cmp++; if (dp_cnt !== 0) begin n_bad++; $display("FAIL noon_day: got %0d want 0", dp_cnt); end
    press(1'b1, 1'b0);
    press_n(1'b0, 1'b1, 11);
    press(1'b1, 1'b0);
    press_n(1'b0, 1'b1, 59);
    press(1'b1, 1'b0);
    n_cmp++; if ({h12, m12, pm12} !== {16'h1159, 1'b1}) begin n_bad++; $display("FAIL set_1159pm: got %h pm %b want 1159 pm 1", {h12, m12}, pm12); end
    dp_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      tick(1);
      if (dp12) dp_cnt++;
    end
    n_cmp++; if ({h12, m12, s12, pm12, dp12} !== {24'h120000, 1'b0, 1'b1}) begin n_bad++; $display("FAIL midnight12: got %h pm %b day %b want 120000 0 1", {h12, m12, s12}, pm12, dp12); end
    n_cmp++; if (dp_cnt !== 1) begin n_bad++; $display("FAIL day_count12: got %0d want 1", dp_cnt); end
  endtask

  task automatic test_alarm;
    int ap_cnt = 0;
    alarm_hour = 8'h00;
    alarm_min  = 8'h02;
    alarm_en   = 1'b1;
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      tick(1);
      if (ap24) ap_cnt++;
    end
    n_cmp++; if ({ap24, m24, s24} !== {1'b1, 16'h0200}) begin n_bad++; $display("FAIL alarm_hit: got pulse %b time %h want 1 0200", ap24, {m24, s24}); end
    for (int c = 0; c < 60; c++) begin
      if (c == 5) alarm_en = 1'b0;
      if (c == 10) alarm_en = 1'b1;
      tick(1);
      if (ap24) ap_cnt++;
    end
    n_cmp++; if (ap_cnt !== 1) begin n_bad++; $display("FAIL alarm_count: got %0d want 1", ap_cnt); end
    alarm_en = 1'b0;
    ap_cnt = 0;
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      tick(1);
      if (ap24) ap_cnt++;
    end
    n_cmp++; if (ap_cnt !== 0) begin n_bad++; $display("FAIL alarm_disabled: got %0d want 0", ap_cnt); end
    alarm_en = 1'b1;
    do_reset();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press_n(1'b0, 1'b1, 2);
    press(1'b1, 1'b0);
    ap_cnt = ap24 ? 1 : 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (ap24) ap_cnt++;
    end
    n_cmp++; if (ap_cnt !== 0) begin n_bad++; $display("FAIL alarm_via_set: got %0d want 0", ap_cnt); end
    n_cmp++; if ({h24, m24, s24} !== 24'h000202) begin n_bad++; $display("FAIL alarm_set_time: got %h want 000202", {h24, m24, s24}); end
    alarm_en = 1'b0;
  endtask

  task automatic test_same_cycle_and_abort;
    do_reset();
    press(1'b0, 1'b1);
    n_cmp++; if ({st24, h24, m24} !== {2'd0, 16'h0000}) begin n_bad++; $display("FAIL inc_in_run: got st %0d %h want 0 0000", st24, {h24, m24}); end
    press(1'b1, 1'b1);
    n_cmp++; if ({st24, h24} !== {2'd1, 8'h00}) begin n_bad++; $display("FAIL mode_wins_hour: got st %0d hour %h want 1 00", st24, h24); end
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    n_cmp++; if ({st24, h24, m24} !== {2'd2, 16'h0100}) begin n_bad++; $display("FAIL mode_wins_min: got st %0d %h want 2 0100", st24, {h24, m24}); end
    press_n(1'b0, 1'b1, 2);
    tick(3);
    n_cmp++; if (m24 !== 8'h02) begin n_bad++; $display("FAIL pre_abort_min: got %h want 02", m24); end
    @(posedge clk);
    #3 resetControl = 1'b1;
    #1;
    n_cmp++; if ({st24, h24, m24, s24} !== {2'd0, 24'h000000}) begin n_bad++; $display("FAIL abort_time: got st %0d %h want 0 000000", st24, {h24, m24, s24}); end
    n_cmp++; if ({bl24, sp24, dp24, ap24, h12} !== {4'b0, 8'h12}) begin n_bad++; $display("FAIL abort_flags: got %b h12 %h want 0000 12", {bl24, sp24, dp24, ap24}, h12); end
    @(posedge clk);
    #1 resetControl = 1'b0;
  endtask

  initial begin
    resetControl = 1'b1;
    tick(2);
    resetControl = 1'b0;
    test_reset();
    test_count();
    test_set_fsm();
    test_rollover_24();
    test_12h();
    test_alarm();
    test_same_cycle_and_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
